phase_acc: RTL

Phase accumulator that feeds the 10-bit phase input of the sine lookup stage. Every `DIV` clocks it adds a frequency tuning word to an `ACC_W`-bit accumulator and presents the top 10 bits as `phase`, qualified by a one-cycle `phase_valid` strobe. New tuning words arrive over a valid/ready handshake and are double-buffered, so a frequency change takes effect exactly on a sample boundary with no phase jump.

---
 rtl/dds_pkg.sv | 16 +
 rtl/tick_gen.sv | 33 +++
 rtl/phase_acc.sv | 102 ++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS front end: phase width, defaults, word type, run state.
package dds_pkg;

   localparam int unsigned PHASE_W   = 10;
   localparam int unsigned ACC_W_DEF = 24;
   localparam int unsigned DIV_DEF   = 50;

   // Tuning word at the default accumulator width
   typedef logic [ACC_W_DEF-1:0] fw_t;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_t;

endpackage

// File: rtl/tick_gen.sv
// Sample-rate prescaler: one tick every DIV clocks while running; clr restarts the period.
module tick_gen
   import dds_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEF
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == CNT_W'(DIV - 1));
   assign o_tick = i_run && w_last && !i_clr;

   // Count 0..DIV-1 while running; any stop, clear or wrap returns to 0
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || !i_run || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/phase_acc.sv
// Phase accumulator with double-buffered tuning word; emits the sine-stage phase address.
module phase_acc
   import dds_pkg::*;
#(
   parameter int unsigned     ACC_W    = ACC_W_DEF,
   parameter int unsigned     DIV      = DIV_DEF,
   parameter logic [ACC_W-1:0] FW_RESET = '0
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic               i_clr,
   input  logic [ACC_W-1:0]   i_fw_data,
   input  logic               i_fw_valid,
   output logic               o_fw_ready,
   output logic [PHASE_W-1:0] o_phase,
   output logic               o_phase_valid,
   output logic               o_wrap
);

   state_t               r_state;
   logic                 w_run;
   logic                 w_tick;
   logic                 w_xfer;
   logic [ACC_W:0]       w_sum;

   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W-1:0]     r_active;
   logic [ACC_W-1:0]     r_pend;
   logic                 r_pend_full;
   logic [PHASE_W-1:0]   r_phase;
   logic                 r_phase_valid;
   logic                 r_wrap;

   // The edge entering RUN leaves the prescaler at 0; dropping en stops it on the same edge
   assign w_run  = (r_state == StRun) && i_en;
   assign w_xfer = i_fw_valid && !r_pend_full;
   assign w_sum  = {1'b0, r_acc} + {1'b0, r_active};

   assign o_fw_ready    = !r_pend_full;
   assign o_phase       = r_phase;
   assign o_phase_valid = r_phase_valid;
   assign o_wrap        = r_wrap;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_run   (w_run),
      .i_clr   (i_clr),
      .o_tick  (w_tick)
   );

   // Run state follows en
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= i_en ? StRun : StIdle;
      end
   end

   // Accumulate on each tick; clr zeroes the phase and suppresses the strobe
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_acc         <= '0;
         r_phase       <= '0;
         r_phase_valid <= 1'b0;
         r_wrap        <= 1'b0;
      end else if (i_clr) begin
         r_acc         <= '0;
         r_phase       <= '0;
         r_phase_valid <= 1'b0;
         r_wrap        <= 1'b0;
      end else if (w_tick) begin
         r_acc         <= w_sum[ACC_W-1:0];
         r_phase       <= w_sum[ACC_W-1 -: PHASE_W];
         r_phase_valid <= 1'b1;
         r_wrap        <= w_sum[ACC_W];
      end else begin
         r_phase_valid <= 1'b0;
         r_wrap        <= 1'b0;
      end
   end

   // Pending/active word buffers: capture when empty, commit only on a sample boundary
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active    <= FW_RESET;
         r_pend      <= '0;
         r_pend_full <= 1'b0;
      end else if (w_tick && r_pend_full) begin
         r_active    <= r_pend;
         r_pend_full <= 1'b0;
      end else if (w_xfer) begin
         r_pend      <= i_fw_data;
         r_pend_full <= 1'b1;
      end
   end

endmodule
